// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each uart byte with a one-cycle rdy_clr ack
// and queues it in a first-word-fall-through FIFO with overrun tracking.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] uart_dout,
  input  logic              uart_rdy,
  output logic              uart_rdy_clr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [DEPTH_LOG2:0] count,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   wr_req;

  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                overrun_q, overrun_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic do_pop, do_wr, drop;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (uart_rdy) state_d = ACK;
      ACK:     state_d = WAIT;
      WAIT:    if (!uart_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_rdy_clr = (state_q == ACK);
    wr_req       = (state_q == IDLE) && uart_rdy;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
  assign do_pop = rd_en && !empty;
  assign do_wr  = wr_req && (!full || do_pop);
  assign drop   = wr_req && full && !do_pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, do_wr};
    rd_ptr_d  = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, do_pop};
    overrun_d = overrun_q;
    if (ovr_clr) overrun_d = 1'b0;
    if (drop)    overrun_d = 1'b1;
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk50) begin
    if (do_wr) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= uart_dout;
  end

  assign rd_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: capture handshake, FWFT data,
// full/overrun boundaries and asynchronous reset.
module tb_uart_rx_fifo;

  logic       clk50 = 1'b0;
  logic       rst_n;
  logic [7:0] uart_dout;
  logic       uart_rdy;
  logic       uart_rdy_clr;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       ovr_clr;

  int vectors = 0;
  int miscompares = 0;

  uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
    .clk50        (clk50),
    .rst_n        (rst_n),
    .uart_dout    (uart_dout),
    .uart_rdy     (uart_rdy),
    .uart_rdy_clr (uart_rdy_clr),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overrun      (overrun),
    .ovr_clr      (ovr_clr)
  );

  always #5 clk50 = ~clk50;

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  // Emulates the uart: rdy held until rdy_clr seen, then dropped.
  task automatic send_byte(input logic [7:0] b, output int pulses);
    uart_dout = b;
    uart_rdy  = 1'b1;
    pulses    = 0;
    for (int i = 0; i < 20 && pulses == 0; i++) begin
      tick();
      if (uart_rdy_clr) pulses++;
    end
    uart_rdy = 1'b0;
    repeat (3) begin
      tick();
      if (uart_rdy_clr) pulses++;
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    vectors++;
    if (uart_rdy_clr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rdy_clr: got %0b want 0", uart_rdy_clr);
    end
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_empty: got %0b want 1", empty);
    end
    vectors++;
    if (full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_full: got %0b want 0", full);
    end
    vectors++;
    if (count !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d want 0", count);
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_overrun: got %0b want 0", overrun);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    uart_dout = 8'hA5;
    uart_rdy  = 1'b1;
    tick();
    vectors++;
    if (empty !== 1'b0 || rd_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_latency: empty=%0b data=%0h want 0 a5", empty, rd_data);
    end
    vectors++;
    if (uart_rdy_clr !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ack: got %0b want 1", uart_rdy_clr);
    end
    uart_rdy = 1'b0;
    tick();
    vectors++;
    if (uart_rdy_clr !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ack_len: got %0b want 0", uart_rdy_clr);
    end
    tick();
    vectors++;
    if (count !== 5'd1) begin
      miscompares++;
      $display("FAIL single_count: got %0d want 1", count);
    end
    pop();
    vectors++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      miscompares++;
      $display("FAIL single_drain: empty=%0b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_pop_empty();
    pop();
    pop();
    vectors++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      miscompares++;
      $display("FAIL pop_empty: empty=%0b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_loopback();
    int p;
    for (int b = 0; b < 256; b++) begin
      send_byte(8'(b), p);
      vectors++;
      if (p != 1) begin
        miscompares++;
        $display("FAIL loop_ack[%0d]: got %0d pulses want 1", b, p);
      end
      vectors++;
      if (rd_data !== 8'(b) || count !== 5'd1) begin
        miscompares++;
        $display("FAIL loop_data[%0d]: data=%0h count=%0d want %0h 1", b, rd_data, count, b);
      end
      vectors++;
      if (overrun !== 1'b0) begin
        miscompares++;
        $display("FAIL loop_ovr[%0d]: got %0b want 0", b, overrun);
      end
      pop();
    end
  endtask

  task automatic test_fill_overrun();
    int p;
    for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i), p);
    vectors++;
    if (full !== 1'b1 || count !== 5'd16) begin
      miscompares++;
      $display("FAIL fill_full: full=%0b count=%0d want 1 16", full, count);
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_no_ovr: got %0b want 0", overrun);
    end
    // 17th byte arrives together with ovr_clr: the set must win.
    uart_dout = 8'hEE;
    uart_rdy  = 1'b1;
    ovr_clr   = 1'b1;
    tick();
    ovr_clr = 1'b0;
    vectors++;
    if (uart_rdy_clr !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_ack: got %0b want 1", uart_rdy_clr);
    end
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_set_wins: got %0b want 1", overrun);
    end
    uart_rdy = 1'b0;
    repeat (3) tick();
    vectors++;
    if (overrun !== 1'b1 || count !== 5'd16) begin
      miscompares++;
      $display("FAIL ovr_sticky: ovr=%0b count=%0d want 1 16", overrun, count);
    end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (rd_data !== 8'h10 + 8'(i)) begin
        miscompares++;
        $display("FAIL fill_order[%0d]: got %0h want %0h", i, rd_data, 8'h10 + 8'(i));
      end
      pop();
    end
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_drain: got %0b want 1", empty);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_clr: got %0b want 0", overrun);
    end
  endtask

  task automatic test_full_pop_write();
    int p;
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), p);
    uart_dout = 8'h77;
    uart_rdy  = 1'b1;
    rd_en     = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++;
    if (count !== 5'd16 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL fullpop_count: count=%0d full=%0b want 16 1", count, full);
    end
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL fullpop_ovr: got %0b want 0", overrun);
    end
    vectors++;
    if (uart_rdy_clr !== 1'b1) begin
      miscompares++;
      $display("FAIL fullpop_ack: got %0b want 1", uart_rdy_clr);
    end
    uart_rdy = 1'b0;
    repeat (3) tick();
    for (int i = 1; i < 17; i++) begin
      vectors++;
      if (rd_data !== ((i == 16) ? 8'h77 : 8'h20 + 8'(i))) begin
        miscompares++;
        $display("FAIL fullpop_order[%0d]: got %0h", i, rd_data);
      end
      pop();
    end
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL fullpop_drain: got %0b want 1", empty);
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    uart_dout = 8'h5C;
    uart_rdy  = 1'b1;
    repeat (10) begin
      tick();
      if (uart_rdy_clr) pulses++;
    end
    uart_rdy = 1'b0;
    repeat (3) begin
      tick();
      if (uart_rdy_clr) pulses++;
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL hold_pulses: got %0d want 1", pulses);
    end
    vectors++;
    if (count !== 5'd1 || rd_data !== 8'h5C) begin
      miscompares++;
      $display("FAIL hold_count: count=%0d data=%0h want 1 5c", count, rd_data);
    end
    pop();
  endtask

  task automatic test_wr_pop_empty();
    uart_dout = 8'h3E;
    uart_rdy  = 1'b1;
    rd_en     = 1'b1;
    tick();
    rd_en    = 1'b0;
    uart_rdy = 1'b0;
    vectors++;
    if (count !== 5'd1 || rd_data !== 8'h3E) begin
      miscompares++;
      $display("FAIL wrpop_empty: count=%0d data=%0h want 1 3e", count, rd_data);
    end
    repeat (3) tick();
    pop();
  endtask

  task automatic test_reset_mid();
    int p;
    send_byte(8'h01, p);
    send_byte(8'h02, p);
    uart_dout = 8'h03;
    uart_rdy  = 1'b1;
    tick();
    vectors++;
    if (uart_rdy_clr !== 1'b1 || count !== 5'd3) begin
      miscompares++;
      $display("FAIL rstmid_pre: ack=%0b count=%0d want 1 3", uart_rdy_clr, count);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (uart_rdy_clr !== 1'b0 || count !== 5'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: ack=%0b count=%0d want 0 0", uart_rdy_clr, count);
    end
    vectors++;
    if (empty !== 1'b1 || overrun !== 1'b0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_flags: empty=%0b ovr=%0b full=%0b want 1 0 0", empty, overrun, full);
    end
    #2 rst_n = 1'b1;
    tick();
    vectors++;
    if (count !== 5'd1 || rd_data !== 8'h03 || uart_rdy_clr !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_recapture: count=%0d data=%0h ack=%0b want 1 03 1",
               count, rd_data, uart_rdy_clr);
    end
    uart_rdy = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    uart_dout = 8'h00;
    uart_rdy  = 1'b0;
    rd_en     = 1'b0;
    ovr_clr   = 1'b0;
    test_reset();
    test_single();
    test_pop_empty();
    test_loopback();
    test_fill_overrun();
    test_full_pop_write();
    test_hold();
    test_wr_pop_empty();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
